// File: rtl/train_scheduler.sv
// Sample/epoch sequencer: loads one sample vector into the operand buffer,
// launches the training controller, and waits for it to return to idle.
module train_scheduler #(
  parameter int numCycle     = 8,
  parameter int logNumCycle  = 3,
  parameter int dataBitwidth = 16,
  parameter int sampleBits   = 16,
  parameter int epochBits    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  logic [sampleBits-1:0]   cfg_num_samples,
  input  logic [epochBits-1:0]    cfg_num_epochs,
  output logic                    cfg_ready,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [dataBitwidth-1:0] in_data,
  output logic                    in_ready,
  output logic                    buf_we,
  output logic [logNumCycle-1:0]  buf_addr,
  output logic [dataBitwidth-1:0] buf_wdata,
  output logic                    ctrl_start,
  output logic                    ctrl_done,
  input  logic [2:0]              ctrl_inst,
  output logic [sampleBits-1:0]   sample_idx,
  output logic [epochBits-1:0]    epoch_idx,
  output logic                    busy,
  output logic                    finished,
  output logic [2:0]              dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_LAUNCH   = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_WAIT_RUN = 3'd4;
  localparam logic [2:0] S_FIN      = 3'd5;

  localparam logic [logNumCycle-1:0] LAST_WORD = logNumCycle'(numCycle - 1);

  logic [2:0]              state_q, state_d;
  logic [sampleBits-1:0]   n_q, n_d;
  logic [epochBits-1:0]    e_q, e_d;
  logic [sampleBits-1:0]   sample_q, sample_d;
  logic [epochBits-1:0]    epoch_q, epoch_d;
  logic [logNumCycle-1:0]  word_q, word_d;
  logic                    we_q, we_d;
  logic [logNumCycle-1:0]  addr_q, addr_d;
  logic [dataBitwidth-1:0] wdata_q, wdata_d;

  logic last_sample;
  logic last_epoch;

  // Terminal compares use the latched counts minus one, so the index
  // counters never need to count past N-1 / E-1.
  assign last_sample = (sample_q == (n_q - sampleBits'(1)));
  assign last_epoch  = (epoch_q == (e_q - epochBits'(1)));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    e_d      = e_q;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
      word_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            n_d      = cfg_num_samples;
            e_d      = cfg_num_epochs;
            sample_d = '0;
            epoch_d  = '0;
            word_d   = '0;
            if ((cfg_num_samples == '0) || (cfg_num_epochs == '0)) begin
              state_d = S_FIN;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            we_d    = 1'b1;
            addr_d  = word_q;
            wdata_d = in_data;
            if (word_q == LAST_WORD) begin
              word_d  = '0;
              state_d = S_LAUNCH;
            end else begin
              word_d = word_q + logNumCycle'(1);
            end
          end
        end
        S_LAUNCH: begin
          state_d = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ctrl_inst != 3'd0) begin
            state_d = S_WAIT_RUN;
          end
        end
        S_WAIT_RUN: begin
          if (ctrl_inst == 3'd0) begin
            if (last_sample && last_epoch) begin
              state_d = S_FIN;
            end else if (last_sample) begin
              sample_d = '0;
              epoch_d  = epoch_q + epochBits'(1);
              state_d  = S_LOAD;
            end else begin
              sample_d = sample_q + sampleBits'(1);
              state_d  = S_LOAD;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      e_q      <= '0;
      sample_q <= '0;
      epoch_q  <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      e_q      <= e_d;
      sample_q <= sample_d;
      epoch_q  <= epoch_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Handshake: a stream word transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on the state register.
  assign cfg_ready  = (state_q == S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign ctrl_start = (state_q == S_LAUNCH);
  assign ctrl_done  = (state_q == S_WAIT_RUN);
  assign finished   = (state_q == S_FIN);
  assign buf_we     = we_q;
  assign buf_addr   = addr_q;
  assign buf_wdata  = wdata_q;
  assign sample_idx = sample_q;
  assign epoch_idx  = epoch_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_train_scheduler.sv
// Bench for train_scheduler: randomized runs against a sample/epoch reference
// model with a behavioural controller; scoreboard checks writes and launches.
module tb_train_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [15:0] cfg_num_samples;
  logic [7:0]  cfg_num_epochs;
  logic        cfg_ready;
  logic        abort;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        buf_we;
  logic [2:0]  buf_addr;
  logic [15:0] buf_wdata;
  logic        ctrl_start;
  logic        ctrl_done;
  logic [2:0]  ctrl_inst;
  logic [15:0] sample_idx;
  logic [7:0]  epoch_idx;
  logic        busy;
  logic        finished;
  logic [2:0]  dbg_state;

  train_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_num_samples(cfg_num_samples),
    .cfg_num_epochs(cfg_num_epochs), .cfg_ready(cfg_ready),
    .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .ctrl_start(ctrl_start), .ctrl_done(ctrl_done), .ctrl_inst(ctrl_inst),
    .sample_idx(sample_idx), .epoch_idx(epoch_idx),
    .busy(busy), .finished(finished), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [18:0] exp_wr_q[$];      // {addr, data}
  logic [23:0] exp_launch_q[$];  // {sample, epoch}
  int tests = 0;
  int fails = 0;
  int launch_cnt = 0;
  int fin_cnt = 0;
  int in_ready_cnt = 0;
  int cfg_cyc = 0;
  int run_end_cyc = -10;
  bit zero_run = 1'b0;
  bit fin_armed = 1'b0;
  int ctrl_run_len = 20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // behavioural training controller: acks a start after a short delay,
  // runs for ctrl_run_len cycles, then returns to inst=0
  initial begin
    ctrl_inst = 3'd0;
    forever begin
      @(negedge clk);
      if (rst_n && ctrl_start) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 ctrl_inst = 3'd1;
        repeat (ctrl_run_len) @(posedge clk);
        #1 ctrl_inst = 3'd0;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_ready) in_ready_cnt++;
      if (buf_we) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_buf_we", 32'(buf_addr), 32'hdead);
        end else begin
          logic [18:0] e;
          e = exp_wr_q.pop_front();
          check("buf_addr", 32'(buf_addr), 32'(e[18:16]));
          check("buf_wdata", 32'(buf_wdata), 32'(e[15:0]));
        end
      end
      if (ctrl_start) begin
        launch_cnt++;
        if (exp_launch_q.size() == 0) begin
          check("unexpected_ctrl_start", 32'(sample_idx), 32'hdead);
        end else begin
          logic [23:0] l;
          l = exp_launch_q.pop_front();
          check("launch_sample_idx", 32'(sample_idx), 32'(l[23:8]));
          check("launch_epoch_idx", 32'(epoch_idx), 32'(l[7:0]));
        end
      end
      if (finished) begin
        fin_cnt++;
        check("finished_expected", 32'(fin_armed), 32'd1);
        if (zero_run) check("finished_after_cfg", 32'(cyc), 32'(cfg_cyc + 1));
        else          check("finished_after_run", 32'(cyc), 32'(run_end_cyc + 1));
        fin_armed = 1'b0;
      end
      if (ctrl_done && ctrl_inst == 3'd0) run_end_cyc = cyc;
    end
  end

  // driver tasks
  task automatic send_word(input logic [15:0] d, input int k);
    int w;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    ok = 1'b0;
    while (!ok && w < 400) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      w++;
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    else exp_wr_q.push_back({3'(k), d});
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 16'($urandom);
  endtask

  task automatic wait_finished(input int n, input int e, input bit zero);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!finished && w < 5000);
    check("finished_seen", 32'(finished), 32'd1);
    check("final_sample_idx", 32'(sample_idx), zero ? 32'd0 : 32'(n - 1));
    check("final_epoch_idx", 32'(epoch_idx), zero ? 32'd0 : 32'(e - 1));
    @(negedge clk);
    check("cfg_ready_after_fin", 32'(cfg_ready), 32'd1);
    check("busy_after_fin", 32'(busy), 32'd0);
  endtask

  task automatic drive_cfg(input int n, input int e);
    cfg_valid       = 1'b1;
    cfg_num_samples = 16'(n);
    cfg_num_epochs  = 8'(e);
    cfg_cyc         = cyc;
    fin_armed       = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    cfg_num_samples = 16'($urandom);
    cfg_num_epochs  = 8'($urandom);
  endtask

  // reference model: every (sample, epoch) pair launches once, in order,
  // each preceded by numCycle buffer writes at addresses 0..7
  task automatic run_cfg(input int n, input int e, input int max_gap, input bit seq, input bit inject);
    int lc0, ir0, gap;
    bit zero;
    zero = (n == 0) || (e == 0);
    if (!zero)
      for (int ep = 0; ep < e; ep++)
        for (int s = 0; s < n; s++)
          exp_launch_q.push_back({16'(s), 8'(ep)});
    lc0 = launch_cnt;
    ir0 = in_ready_cnt;
    zero_run = zero;
    drive_cfg(n, e);
    if (!zero) begin
      for (int i = 0; i < n * e; i++) begin
        for (int k = 0; k < 8; k++) begin
          gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          if (inject && i == 0 && k == 3) begin
            cfg_valid = 1'b1;
            cfg_num_samples = 16'd7;
            cfg_num_epochs  = 8'd9;
            @(posedge clk);
            #1 cfg_valid = 1'b0;
          end
          send_word(seq ? 16'(k + 1) : 16'($urandom), k);
        end
      end
    end
    wait_finished(n, e, zero);
    check("launch_count", 32'(launch_cnt - lc0), 32'(n * e));
    check("launches_drained", 32'(exp_launch_q.size()), 32'd0);
    check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
    if (zero) check("in_ready_never_high", 32'(in_ready_cnt - ir0), 32'd0);
  endtask

  initial begin
    int w, fb;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_num_samples = '0;
    cfg_num_epochs = '0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_buf_we", 32'(buf_we), 32'd0);
    check("rst_ctrl_start", 32'(ctrl_start), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single sample, sequential data, 20-cycle controller run
    ctrl_run_len = 20;
    run_cfg(1, 1, 0, 1'b1, 1'b0);

    // multi-epoch with gaps and an ignored mid-LOAD configuration
    ctrl_run_len = 6;
    run_cfg(3, 2, 3, 1'b0, 1'b1);

    // zero configuration
    run_cfg(0, 5, 0, 1'b0, 1'b0);

    // random runs
    for (int r = 0; r < 3; r++) begin
      ctrl_run_len = $urandom_range(2, 10);
      run_cfg($urandom_range(1, 3), $urandom_range(1, 2), 2, 1'b0, 1'b0);
    end

    // abort during WAIT_RUN of sample 2
    ctrl_run_len = 20;
    for (int s = 0; s < 3; s++) exp_launch_q.push_back({16'(s), 8'd0});
    zero_run = 1'b0;
    drive_cfg(4, 1);
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 8; k++) send_word(16'($urandom), k);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!ctrl_done && w < 200);
    check("abort_reached_wait_run", 32'(ctrl_done), 32'd1);
    check("abort_sample_before", 32'(sample_idx), 32'd2);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    fin_armed = 1'b0;
    fb = fin_cnt;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ctrl_done", 32'(ctrl_done), 32'd0);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd1);
    check("abort_sample_held", 32'(sample_idx), 32'd2);
    w = 0;
    while (ctrl_inst != 3'd0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("abort_no_finished", 32'(fin_cnt - fb), 32'd0);
    check("abort_launches", 32'(exp_launch_q.size()), 32'd0);
    @(posedge clk);
    #1;
    ctrl_run_len = 4;
    run_cfg(1, 1, 0, 1'b1, 1'b0);

    // asynchronous reset mid-LOAD while a write is being presented
    exp_launch_q.push_back({16'd0, 8'd0});
    zero_run = 1'b0;
    drive_cfg(1, 1);
    for (int k = 0; k < 3; k++) send_word(16'(16'h100 + k), k);
    check("pre_rst_buf_we", 32'(buf_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_buf_we", 32'(buf_we), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    check("async_rst_buf_addr", 32'(buf_addr), 32'd0);
    check("async_rst_buf_wdata", 32'(buf_wdata), 32'd0);
    check("async_rst_sample_idx", 32'(sample_idx), 32'd0);
    exp_wr_q.delete();
    exp_launch_q.delete();
    fin_armed = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);

    ctrl_run_len = 5;
    run_cfg(2, 1, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
